uart_b2b_core: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_core.sv | 134 +++++++++++++
 rtl/uart_tx_core.sv | 92 +++++++++
 rtl/uart_b2b_core.sv | 55 +++++
 tb/tb_uart_b2b_core.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg
// Shared constants, frame-state encoding and parity helper for the
// back-to-back UART (8 data bits, one parity bit, one stop bit).
// No ports: imported by uart_tx_core, uart_rx_core and uart_b2b_core.
package uart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int OVERSAMPLE   = 16;
  localparam int BIT_CNT_W    = $clog2(DATA_BITS);
  localparam int SAMPLE_CNT_W = $clog2(OVERSAMPLE);
  // Mid-bit sample position within one bit period.
  localparam int MID_SAMPLE   = OVERSAMPLE / 2 - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  // Parity bit that makes the frame even (odd = 0) or odd (odd = 1).
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data,
                                     input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// uart_rx_core
// Receives 8-bit parity frames from the oversampled line, samples mid-bit,
// and presents the byte with parity/framing/overrun status to the CPU.
// Ports:
//   clk16x         16x baud clock
//   rst_n          synchronous active-low reset
//   rx_in          serial line (asynchronous to the receiver's view)
//   uld_rx_data    CPU unloads the byte: rx_empty=1, flags clear
//   rx_enable      hunt for new start bits only while 1
//   rx_data        last received byte
//   rx_empty       0 = unread byte available
//   rx_parity_err  parity mismatch on rx_data
//   rx_frame_err   stop bit sampled 0 on rx_data
//   rx_overrun     frame completed while a byte was unread; sticky until unload
module uart_rx_core
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk16x,
  input  logic                 rst_n,
  input  logic                 rx_in,
  input  logic                 uld_rx_data,
  input  logic                 rx_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  frame_state_e             state_q, state_d;
  logic                     sync1_q, sync2_q, prev_q;
  logic [SAMPLE_CNT_W-1:0]  cnt_q;
  logic [BIT_CNT_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0]     shift_q;
  logic                     par_q;
  logic                     line, fall, sample_pt, bit_end;
  logic                     shift_en, par_en, done;

  assign line      = sync2_q;
  assign fall      = prev_q & ~sync2_q;
  assign sample_pt = (cnt_q == SAMPLE_CNT_W'(MID_SAMPLE));
  assign bit_end   = (cnt_q == SAMPLE_CNT_W'(OVERSAMPLE - 1));

  // Two-flop synchronizer plus one history flop for edge detection.
  // Reset to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge clk16x) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk16x) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (rx_enable && fall) state_d = START;
      START: begin
        if (sample_pt && line) state_d = IDLE;   // false start
        else if (bit_end)      state_d = DATA;
      end
      DATA:   if (bit_end && bit_idx_q == BIT_CNT_W'(DATA_BITS - 1)) state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
      // Return to hunting at mid-stop so a back-to-back start edge is seen.
      STOP:   if (sample_pt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    par_en   = 1'b0;
    done     = 1'b0;
    case (state_q)
      DATA:    shift_en = sample_pt;
      PARITY:  par_en   = sample_pt;
      STOP:    done     = sample_pt;
      default: ;
    endcase
  end

  // The edge-detect cycle counts as sample 0 of the start bit, hence the
  // counter idles at 1.
  always_ff @(posedge clk16x) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
    end else begin
      cnt_q <= (state_q == IDLE) ? SAMPLE_CNT_W'(1) : cnt_q + 1'b1;
      if (state_q != DATA)  bit_idx_q <= '0;
      else if (bit_end)     bit_idx_q <= bit_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk16x) begin
    if (shift_en) shift_q <= {line, shift_q[DATA_BITS-1:1]};
    if (par_en)   par_q   <= line;
  end

  // A completing frame takes priority over a same-cycle unload.
  always_ff @(posedge clk16x) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_empty      <= 1'b1;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (done) begin
      rx_data       <= shift_q;
      rx_empty      <= 1'b0;
      rx_parity_err <= par_q ^ parity_of(shift_q, PARITY_ODD);
      rx_frame_err  <= ~line;
      rx_overrun    <= ~rx_empty & ~uld_rx_data;
    end else if (uld_rx_data) begin
      rx_empty      <= 1'b1;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
`timescale 1ns/1ps
// uart_tx_core
// Serialises one byte per frame: start(0), D0..D7 LSB first, parity, stop(1).
// One holding register; it stays occupied until the stop bit has been sent.
// Ports:
//   clk16x      16x baud clock
//   rst_n       synchronous active-low reset
//   ld_tx_data  load tx_data when tx_empty = 1
//   tx_data     byte to transmit
//   tx_enable   frame may start only while 1 (checked at frame boundaries)
//   tx_empty    1 = holding register free
//   tx_out      serial line, idle high
module uart_tx_core
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk16x,
  input  logic                 rst_n,
  input  logic                 ld_tx_data,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_enable,
  output logic                 tx_empty,
  output logic                 tx_out
);

  frame_state_e             state_q, state_d;
  logic [SAMPLE_CNT_W-1:0]  cnt_q;
  logic [BIT_CNT_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0]     hold_q;
  logic                     full_q;
  logic                     load_ok;
  logic                     bit_end;

  assign load_ok  = ld_tx_data & ~full_q;
  assign bit_end  = (cnt_q == SAMPLE_CNT_W'(OVERSAMPLE - 1));
  assign tx_empty = ~full_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk16x) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_enable && (full_q || load_ok)) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && bit_idx_q == BIT_CNT_W'(DATA_BITS - 1)) state_d = PARITY;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_out = 1'b1;
    case (state_q)
      START:   tx_out = 1'b0;
      DATA:    tx_out = hold_q[bit_idx_q];
      PARITY:  tx_out = parity_of(hold_q, PARITY_ODD);
      default: tx_out = 1'b1;
    endcase
  end

  // Bit timing: the counter sits at 0 while idle, so the first bit period
  // begins on the cycle after the frame is started.
  always_ff @(posedge clk16x) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      full_q    <= 1'b0;
    end else begin
      cnt_q <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
      if (state_q != DATA)  bit_idx_q <= '0;
      else if (bit_end)     bit_idx_q <= bit_idx_q + 1'b1;
      if (load_ok)                            full_q <= 1'b1;
      else if (state_q == STOP && bit_end)    full_q <= 1'b0;
    end
  end

  // NOTE: the holding register carries no reset; it is only read after a
  // load has written it, and full_q (which is reset) gates that.
  always_ff @(posedge clk16x) begin
    if (load_ok) hold_q <= tx_data;
  end

endmodule

// File: rtl/uart_b2b_core.sv
`timescale 1ns/1ps
// uart_b2b_core
// Back-to-back UART: the transmitter's serial output feeds the receiver.
// Ports:
//   clk16x, rst_n                         16x baud clock, sync active-low reset
//   ld_tx_data, tx_data, tx_enable        TX load side
//   tx_empty, tx_out                      TX status and serial line
//   uld_rx_data, rx_enable                RX unload / hunt enable
//   rx_data, rx_empty                     received byte and availability
//   rx_parity_err, rx_frame_err, rx_overrun  status of the byte in rx_data
module uart_b2b_core
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk16x,
  input  logic                 rst_n,
  input  logic                 ld_tx_data,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_enable,
  output logic                 tx_empty,
  output logic                 tx_out,
  input  logic                 uld_rx_data,
  input  logic                 rx_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  uart_tx_core #(.PARITY_ODD(PARITY_ODD)) u_tx (
    .clk16x     (clk16x),
    .rst_n      (rst_n),
    .ld_tx_data (ld_tx_data),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .tx_empty   (tx_empty),
    .tx_out     (tx_out)
  );

  uart_rx_core #(.PARITY_ODD(PARITY_ODD)) u_rx (
    .clk16x        (clk16x),
    .rst_n         (rst_n),
    .rx_in         (tx_out),
    .uld_rx_data   (uld_rx_data),
    .rx_enable     (rx_enable),
    .rx_data       (rx_data),
    .rx_empty      (rx_empty),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun)
  );

endmodule

// File: tb/tb_uart_b2b_core.sv
`timescale 1ns/1ps
module tb_uart_b2b_core;

  localparam bit PARITY_ODD = 1'b0;
  localparam int BIT_CYC    = 16;
  localparam int FRAME_CYC  = 11 * BIT_CYC;   // 176
  localparam int RX_LAT     = 171;
  localparam int TX_FREE    = FRAME_CYC + 1;  // 177

  logic       clk16x = 1'b0;
  logic       rst_n;
  logic       ld_tx_data;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_empty;
  logic       tx_out;
  logic       uld_rx_data;
  logic       rx_enable;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk16x = ~clk16x;

  uart_b2b_core #(.PARITY_ODD(PARITY_ODD)) dut (
    .clk16x        (clk16x),
    .rst_n         (rst_n),
    .ld_tx_data    (ld_tx_data),
    .tx_data       (tx_data),
    .tx_enable     (tx_enable),
    .tx_empty      (tx_empty),
    .tx_out        (tx_out),
    .uld_rx_data   (uld_rx_data),
    .rx_enable     (rx_enable),
    .rx_data       (rx_data),
    .rx_empty      (rx_empty),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun)
  );

  // Reference model: the k-th line bit of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int ones;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return ((ones % 2) == 1) ^ PARITY_ODD;
    end
    return 1'b1;
  endfunction

  // Advance one cycle; inputs are driven and outputs observed 1 ns after the edge.
  task automatic step();
    @(posedge clk16x);
    #1;
    cyc++;
  endtask

  task automatic wait_tx_empty(output bit ok);
    for (int i = 0; i < 400 && tx_empty !== 1'b1; i++) step();
    ok = (tx_empty === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_tx_data = 1'b0; uld_rx_data = 1'b0;
    tx_enable = 1'b1; rx_enable = 1'b1; tx_data = 8'h00;
    repeat (4) step();
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx_out: got %b expected 1", tx_out); end
    checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_tx_empty: got %b expected 1", tx_empty); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if ({rx_parity_err, rx_frame_err, rx_overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {rx_parity_err, rx_frame_err, rx_overrun}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    b = 8'hA5;
    tx_data = b; ld_tx_data = 1'b1;
    step();
    ld_tx_data = 1'b0;
    for (int c = 1; c <= TX_FREE; c++) begin
      if (c <= FRAME_CYC) begin
        checks++;
        if (tx_out !== frame_bit(b, (c - 1) / BIT_CYC)) begin
          errors++; $display("FAIL single_tx_out cycle %0d: got %b expected %b", c, tx_out, frame_bit(b, (c - 1) / BIT_CYC));
        end
      end
      checks++; if (tx_empty !== (c >= TX_FREE)) begin errors++; $display("FAIL single_tx_empty cycle %0d: got %b expected %b", c, tx_empty, c >= TX_FREE); end
      checks++; if (rx_empty !== (c < RX_LAT)) begin errors++; $display("FAIL single_rx_empty cycle %0d: got %b expected %b", c, rx_empty, c < RX_LAT); end
      if (c == RX_LAT) begin
        checks++;
        if ({rx_data, rx_parity_err, rx_frame_err, rx_overrun} !== {b, 3'b000}) begin
          errors++; $display("FAIL single_rx_byte: got %h/%b expected %h/000", rx_data, {rx_parity_err, rx_frame_err, rx_overrun}, b);
        end
      end
      if (c < TX_FREE) step();
    end
    uld_rx_data = 1'b1;
    step();
    uld_rx_data = 1'b0;
    checks++; if (rx_empty !== 1'b1 || rx_data !== b) begin errors++; $display("FAIL single_unload: got empty=%b data=%h expected empty=1 data=%h", rx_empty, rx_data, b); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b, e;
    int sent = 0, got = 0, last_load = -1, perr = 0, ferr = 0;
    for (int n = 0; n < 20 * TX_FREE + 500 && got < 20; n++) begin
      ld_tx_data = 1'b0; uld_rx_data = 1'b0;
      if (rx_empty === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected: got %h expected no byte", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_data !== e) begin errors++; $display("FAIL b2b_byte %0d: got %h expected %h", got, rx_data, e); end
        end
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun %0d: got %b expected 0", got, rx_overrun); end
        perr += int'(rx_parity_err);
        ferr += int'(rx_frame_err);
        got++;
        uld_rx_data = 1'b1;
      end
      if (tx_empty === 1'b1 && sent < 20) begin
        b = 8'($urandom());
        tx_data = b; ld_tx_data = 1'b1;
        exp_q.push_back(b);
        if (last_load >= 0) begin
          checks++; if (cyc - last_load != TX_FREE) begin errors++; $display("FAIL b2b_load_gap: got %0d expected %0d", cyc - last_load, TX_FREE); end
        end
        last_load = cyc;
        sent++;
      end
      step();
    end
    ld_tx_data = 1'b0; uld_rx_data = 1'b0;
    checks++; if (got != 20) begin errors++; $display("FAIL b2b_count: got %0d expected 20", got); end
    checks++; if (perr != 0) begin errors++; $display("FAIL b2b_parity_errs: got %0d expected 0", perr); end
    checks++; if (ferr != 0) begin errors++; $display("FAIL b2b_frame_errs: got %0d expected 0", ferr); end
  endtask

  task automatic test_overrun();
    bit ok;
    wait_tx_empty(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_wait0: got busy expected tx_empty"); end
    tx_data = 8'h3C; ld_tx_data = 1'b1;
    step();
    ld_tx_data = 1'b0;
    wait_tx_empty(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_wait1: got busy expected tx_empty"); end
    checks++; if ({rx_empty, rx_data, rx_overrun} !== {1'b0, 8'h3C, 1'b0}) begin errors++; $display("FAIL ovr_first: got %b/%h/%b expected 0/3c/0", rx_empty, rx_data, rx_overrun); end
    tx_data = 8'hFF; ld_tx_data = 1'b1;
    step();
    ld_tx_data = 1'b0;
    repeat (RX_LAT - 2) step();   // frame cycle 170
    checks++; if (rx_overrun !== 1'b0 || rx_data !== 8'h3C) begin errors++; $display("FAIL ovr_early: got ovr=%b data=%h expected 0/3c", rx_overrun, rx_data); end
    step();                       // frame cycle 171
    checks++; if ({rx_empty, rx_data, rx_overrun, rx_parity_err, rx_frame_err} !== {1'b0, 8'hFF, 3'b100}) begin errors++; $display("FAIL ovr_second: got %b/%h/%b%b%b expected 0/ff/100", rx_empty, rx_data, rx_overrun, rx_parity_err, rx_frame_err); end
    uld_rx_data = 1'b1;
    step();
    uld_rx_data = 1'b0;
    checks++; if ({rx_empty, rx_overrun, rx_data} !== {1'b1, 1'b0, 8'hFF}) begin errors++; $display("FAIL ovr_clear: got %b/%b/%h expected 1/0/ff", rx_empty, rx_overrun, rx_data); end
  endtask

  task automatic test_ignore_load();
    bit ok;
    logic [7:0] b;
    int bad = 0;
    wait_tx_empty(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_wait: got busy expected tx_empty"); end
    b = 8'($urandom());
    if (b == 8'h55) b = 8'hAA;
    tx_data = b; ld_tx_data = 1'b1;
    step();
    for (int c = 1; c <= TX_FREE; c++) begin
      ld_tx_data = (c == 40);
      tx_data    = (c == 40) ? 8'h55 : b;
      if (c <= FRAME_CYC) begin
        checks++;
        if (tx_out !== frame_bit(b, (c - 1) / BIT_CYC)) begin
          errors++; $display("FAIL ign_tx_out cycle %0d: got %b expected %b", c, tx_out, frame_bit(b, (c - 1) / BIT_CYC));
        end
      end
      if (c == RX_LAT) begin
        checks++; if (rx_empty !== 1'b0 || rx_data !== b) begin errors++; $display("FAIL ign_rx: got %b/%h expected 0/%h", rx_empty, rx_data, b); end
      end
      if (c < TX_FREE) step();
    end
    ld_tx_data = 1'b0;
    uld_rx_data = 1'b1;
    step();
    uld_rx_data = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_out !== 1'b1 || rx_empty !== 1'b1) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ign_no_second_frame: got %0d busy cycles expected 0", bad); end
  endtask

  task automatic test_tx_enable_hold();
    logic [7:0] b;
    int bad = 0;
    tx_enable = 1'b0;
    b = 8'($urandom());
    tx_data = b; ld_tx_data = 1'b1;
    step();
    ld_tx_data = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (tx_out !== 1'b1 || tx_empty !== 1'b0) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_idle: got %0d bad cycles expected 0", bad); end
    tx_enable = 1'b1;
    step();                       // frame cycle 1
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL hold_start: got %b expected 0", tx_out); end
    repeat (RX_LAT - 2) step();   // frame cycle 170
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL hold_rx_early: got %b expected 1", rx_empty); end
    step();                       // frame cycle 171
    checks++; if (rx_empty !== 1'b0 || rx_data !== b) begin errors++; $display("FAIL hold_rx: got %b/%h expected 0/%h", rx_empty, rx_data, b); end
    uld_rx_data = 1'b1;
    step();
    uld_rx_data = 1'b0;
  endtask

  task automatic test_rx_enable();
    bit ok;
    logic [7:0] b;
    int bad = 0;
    wait_tx_empty(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rxen_wait: got busy expected tx_empty"); end
    rx_enable = 1'b0;
    tx_data = 8'($urandom()); ld_tx_data = 1'b1;
    step();
    ld_tx_data = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rx_empty !== 1'b1) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rxen_blocked: got %0d full cycles expected 0", bad); end
    rx_enable = 1'b1;
    b = 8'($urandom());
    tx_data = b; ld_tx_data = 1'b1;
    step();
    ld_tx_data = 1'b0;
    for (int c = 1; c < RX_LAT; c++) begin
      if (c == 50) rx_enable = 1'b0;
      step();
    end
    checks++; if (rx_empty !== 1'b0 || rx_data !== b) begin errors++; $display("FAIL rxen_midframe: got %b/%h expected 0/%h", rx_empty, rx_data, b); end
    rx_enable = 1'b1;
    uld_rx_data = 1'b1;
    step();
    uld_rx_data = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int bad = 0;
    wait_tx_empty(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmf_wait: got busy expected tx_empty"); end
    tx_data = 8'($urandom()); ld_tx_data = 1'b1;
    step();
    ld_tx_data = 1'b0;
    repeat (79) step();           // frame cycle 80
    rst_n = 1'b0;
    step();
    checks++; if (tx_out !== 1'b1 || tx_empty !== 1'b1 || rx_empty !== 1'b1) begin errors++; $display("FAIL rmf_abort: got out=%b tx_empty=%b rx_empty=%b expected 1/1/1", tx_out, tx_empty, rx_empty); end
    rst_n = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if (tx_out !== 1'b1 || rx_empty !== 1'b1) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmf_quiet: got %0d busy cycles expected 0", bad); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rmf_rx_data: got %h expected 00", rx_data); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_ignore_load();
    test_tx_enable_hold();
    test_rx_enable();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
